// File: rtl/flappy_game_ctrl.sv
// Game sequencer for the 16x16 flappy bird display: IDLE/PLAY/CRASH/OVER FSM, bird/pipe step
// enables, score/high score tracking and score-driven pipe speed ramp.
module flappy_game_ctrl #(
  parameter int unsigned BIRD_DIV      = 12_500_000,
  parameter int unsigned PIPE_DIV_INIT = 25_000_000,
  parameter int unsigned PIPE_DIV_MIN  = 6_250_000,
  parameter int unsigned DIV_DEC       = 2_500_000,
  parameter int unsigned SPEEDUP_STEP  = 5,
  parameter int unsigned MAX_LEVEL     = 7,
  parameter int unsigned CRASH_CYC     = 100_000_000,
  parameter int unsigned FLASH_DIV     = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       press,
  input  logic       collision,
  input  logic       score_pulse,
  output logic       bird_tick,
  output logic       pipe_tick,
  output logic       game_rst,
  output logic       crash_flash,
  output logic [1:0] state,
  output logic [9:0] score,
  output logic [9:0] high_score,
  output logic [2:0] level
);

  localparam int unsigned BirdW  = (BIRD_DIV > 1) ? $clog2(BIRD_DIV) : 1;
  localparam int unsigned PipeW  = $clog2(PIPE_DIV_INIT + 1);
  localparam int unsigned StepW  = (SPEEDUP_STEP > 1) ? $clog2(SPEEDUP_STEP) : 1;
  localparam int unsigned CrashW = (CRASH_CYC > 1) ? $clog2(CRASH_CYC) : 1;
  localparam int unsigned FlashW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [9:0]  ScoreMax = 10'd999;

  typedef enum logic [1:0] {StIdle = 2'd0, StPlay = 2'd1, StCrash = 2'd2, StOver = 2'd3} state_e;

  state_e            state_q, state_d;
  logic              press_prev_q;
  logic [BirdW-1:0]  bird_cnt_q, bird_cnt_d;
  logic [PipeW-1:0]  pipe_cnt_q, pipe_cnt_d;
  logic [PipeW-1:0]  pipe_period_q, pipe_period_d;
  logic [StepW-1:0]  step_q, step_d;
  logic [2:0]        level_q, level_d;
  logic [9:0]        score_q, score_d;
  logic [9:0]        high_q, high_d;
  logic [CrashW-1:0] crash_cnt_q, crash_cnt_d;
  logic [FlashW-1:0] flash_cnt_q, flash_cnt_d;
  logic              flash_q, flash_d;
  logic              bird_tick_q, bird_tick_d;
  logic              pipe_tick_q, pipe_tick_d;
  logic              game_rst_q, game_rst_d;
  logic              press_rise;
  logic [31:0]       pipe_dec;
  logic [PipeW-1:0]  pipe_target;

  // Held button after reset must not start a game, hence press_prev_q resets to 1.
  assign press_rise = press & ~press_prev_q;

  always_comb begin
    pipe_dec = 32'(level_q) * DIV_DEC;
    if (pipe_dec + PIPE_DIV_MIN > PIPE_DIV_INIT) begin
      pipe_target = PipeW'(PIPE_DIV_MIN);
    end else begin
      pipe_target = PipeW'(PIPE_DIV_INIT - pipe_dec);
    end
  end

  always_comb begin
    state_d       = state_q;
    bird_cnt_d    = bird_cnt_q;
    pipe_cnt_d    = pipe_cnt_q;
    pipe_period_d = pipe_period_q;
    step_d        = step_q;
    level_d       = level_q;
    score_d       = score_q;
    high_d        = high_q;
    crash_cnt_d   = crash_cnt_q;
    flash_cnt_d   = flash_cnt_q;
    flash_d       = flash_q;
    bird_tick_d   = 1'b0;
    pipe_tick_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (press_rise) begin
          state_d       = StPlay;
          score_d       = '0;
          level_d       = '0;
          step_d        = '0;
          pipe_period_d = PipeW'(PIPE_DIV_INIT);
          bird_cnt_d    = '0;
          pipe_cnt_d    = '0;
        end
      end
      StPlay: begin
        if (collision) begin
          // Dividers freeze on this edge too so no tick leaks into the first CRASH cycle.
          state_d     = StCrash;
          crash_cnt_d = '0;
          flash_cnt_d = '0;
          flash_d     = 1'b1;
        end else begin
          if (bird_cnt_q == BirdW'(BIRD_DIV - 1)) begin
            bird_cnt_d  = '0;
            bird_tick_d = 1'b1;
          end else begin
            bird_cnt_d = bird_cnt_q + BirdW'(1);
          end
          if (pipe_cnt_q == pipe_period_q - PipeW'(1)) begin
            pipe_cnt_d    = '0;
            pipe_tick_d   = 1'b1;
            pipe_period_d = pipe_target;
          end else begin
            pipe_cnt_d = pipe_cnt_q + PipeW'(1);
          end
          if (score_pulse) begin
            if (score_q != ScoreMax) begin
              score_d = score_q + 10'd1;
            end
            if (step_q == StepW'(SPEEDUP_STEP - 1)) begin
              step_d = '0;
              if (level_q != 3'(MAX_LEVEL)) begin
                level_d = level_q + 3'd1;
              end
            end else begin
              step_d = step_q + StepW'(1);
            end
          end
        end
      end
      StCrash: begin
        crash_cnt_d = crash_cnt_q + CrashW'(1);
        if (flash_cnt_q == FlashW'(FLASH_DIV - 1)) begin
          flash_cnt_d = '0;
          flash_d     = ~flash_q;
        end else begin
          flash_cnt_d = flash_cnt_q + FlashW'(1);
        end
        if (crash_cnt_q == CrashW'(CRASH_CYC - 1)) begin
          state_d = StOver;
          flash_d = 1'b0;
          if (score_q > high_q) begin
            high_d = score_q;
          end
        end
      end
      StOver: begin
        if (press_rise) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    game_rst_d = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      press_prev_q  <= 1'b1;
      bird_cnt_q    <= '0;
      pipe_cnt_q    <= '0;
      pipe_period_q <= PipeW'(PIPE_DIV_INIT);
      step_q        <= '0;
      level_q       <= '0;
      score_q       <= '0;
      high_q        <= '0;
      crash_cnt_q   <= '0;
      flash_cnt_q   <= '0;
      flash_q       <= 1'b0;
      bird_tick_q   <= 1'b0;
      pipe_tick_q   <= 1'b0;
      game_rst_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      press_prev_q  <= press;
      bird_cnt_q    <= bird_cnt_d;
      pipe_cnt_q    <= pipe_cnt_d;
      pipe_period_q <= pipe_period_d;
      step_q        <= step_d;
      level_q       <= level_d;
      score_q       <= score_d;
      high_q        <= high_d;
      crash_cnt_q   <= crash_cnt_d;
      flash_cnt_q   <= flash_cnt_d;
      flash_q       <= flash_d;
      bird_tick_q   <= bird_tick_d;
      pipe_tick_q   <= pipe_tick_d;
      game_rst_q    <= game_rst_d;
    end
  end

  assign state       = state_q;
  assign bird_tick   = bird_tick_q;
  assign pipe_tick   = pipe_tick_q;
  assign game_rst    = game_rst_q;
  assign crash_flash = flash_q;
  assign score       = score_q;
  assign high_score  = high_q;
  assign level       = level_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Self-checking bench for flappy_game_ctrl with small dividers; expectations are queued when
// stimulus is driven and compared after the following clock edge.
module tb_flappy_game_ctrl;

  logic       clk = 1'b0;
  logic       rst, press, collision, score_pulse;
  logic       bird_tick, pipe_tick, game_rst, crash_flash;
  logic [1:0] state;
  logic [9:0] score, high_score;
  logic [2:0] level;

  flappy_game_ctrl #(
    .BIRD_DIV(4), .PIPE_DIV_INIT(10), .PIPE_DIV_MIN(4), .DIV_DEC(2),
    .SPEEDUP_STEP(2), .MAX_LEVEL(7), .CRASH_CYC(20), .FLASH_DIV(5)
  ) dut (
    .clk(clk), .rst(rst), .press(press), .collision(collision), .score_pulse(score_pulse),
    .bird_tick(bird_tick), .pipe_tick(pipe_tick), .game_rst(game_rst),
    .crash_flash(crash_flash), .state(state), .score(score), .high_score(high_score),
    .level(level)
  );

  always #5 clk = ~clk;

  localparam int SelState = 0, SelScore = 1, SelHigh = 2, SelLevel = 3;
  localparam int SelBird = 4, SelPipe = 5, SelGrst = 6, SelFlash = 7;

  typedef struct {
    string name;
    int    sel;
    int    val;
  } exp_t;

  typedef struct {
    bit press;
    int st;
    bit bt;
    bit pt;
    bit gr;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[22];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic int dut_val(int sel);
    case (sel)
      SelState: return int'(state);
      SelScore: return int'(score);
      SelHigh:  return int'(high_score);
      SelLevel: return int'(level);
      SelBird:  return int'(bird_tick);
      SelPipe:  return int'(pipe_tick);
      SelGrst:  return int'(game_rst);
      SelFlash: return int'(crash_flash);
      default:  return -1;
    endcase
  endfunction

  task automatic expect_v(input string name, input int sel, input int val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic compare(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compare(e.name, dut_val(e.sel), e.val);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk();
    cyc();
    drain();
  endtask

  // Returns the cycle count to the next pipe_tick, or -1 if it never comes.
  task automatic pipe_gap(output int gap);
    gap = -1;
    for (int n = 1; n <= 50; n++) begin
      cyc();
      if (pipe_tick) begin
        gap = n;
        break;
      end
    end
  endtask

  // Collision coincides with a score pulse; score must hold, then a 20-cycle flashing crash.
  task automatic run_crash(input int exp_score, input int exp_high);
    for (int k = 0; k < 20; k++) begin
      collision   = (k == 0);
      score_pulse = (k == 0);
      press       = (k == 2);
      expect_v("crash_state", SelState, 2);
      expect_v("crash_score", SelScore, exp_score);
      expect_v("crash_flash", SelFlash, ((k / 5) % 2 == 0) ? 1 : 0);
      expect_v("crash_bird", SelBird, 0);
      expect_v("crash_pipe", SelPipe, 0);
      expect_v("crash_grst", SelGrst, 0);
      step_chk();
    end
    press = 1'b0;
    expect_v("over_state", SelState, 3);
    expect_v("over_flash", SelFlash, 0);
    expect_v("over_high", SelHigh, exp_high);
    expect_v("over_score", SelScore, exp_score);
    step_chk();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;

    vecs[0] = '{press: 1'b0, st: 0, bt: 1'b0, pt: 1'b0, gr: 1'b1};
    vecs[1] = '{press: 1'b1, st: 1, bt: 1'b0, pt: 1'b0, gr: 1'b0};
    for (int c = 1; c <= 20; c++) begin
      vecs[c + 1] = '{press: (c == 2 || c == 3), st: 1, bt: (c % 4 == 0),
                      pt: (c % 10 == 0), gr: 1'b0};
    end

    rst = 1'b0; press = 1'b1; collision = 1'b0; score_pulse = 1'b0;
    cyc();
    expect_v("rst_state", SelState, 0);
    expect_v("rst_score", SelScore, 0);
    expect_v("rst_high", SelHigh, 0);
    expect_v("rst_level", SelLevel, 0);
    expect_v("rst_bird", SelBird, 0);
    expect_v("rst_pipe", SelPipe, 0);
    expect_v("rst_grst", SelGrst, 1);
    expect_v("rst_flash", SelFlash, 0);
    step_chk();

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_v("held_state", SelState, 0);
      expect_v("held_grst", SelGrst, 1);
      expect_v("held_bird", SelBird, 0);
      expect_v("held_pipe", SelPipe, 0);
      step_chk();
    end

    // Start, then PLAY cycles 1..20: bird every 4, pipe every 10, presses ignored.
    foreach (vecs[i]) begin
      press = vecs[i].press;
      expect_v($sformatf("vec%0d_state", i), SelState, vecs[i].st);
      expect_v($sformatf("vec%0d_bird", i), SelBird, int'(vecs[i].bt));
      expect_v($sformatf("vec%0d_pipe", i), SelPipe, int'(vecs[i].pt));
      expect_v($sformatf("vec%0d_grst", i), SelGrst, int'(vecs[i].gr));
      step_chk();
    end
    press = 1'b0;

    for (int i = 1; i <= 4; i++) begin
      score_pulse = 1'b1;
      expect_v("ramp_score", SelScore, i);
      expect_v("ramp_level", SelLevel, i / 2);
      step_chk();
    end
    score_pulse = 1'b0;
    pipe_gap(gap);
    compare("pipe_first_after_lvl2", (gap > 0) ? 1 : 0, 1);
    pipe_gap(gap);
    compare("pipe_gap_lvl2", gap, 6);
    pipe_gap(gap);
    compare("pipe_gap_lvl2_again", gap, 6);

    for (int i = 5; i <= 16; i++) begin
      score_pulse = 1'b1;
      expect_v("sat_score", SelScore, i);
      expect_v("sat_level", SelLevel, (i / 2 > 7) ? 7 : i / 2);
      step_chk();
    end
    score_pulse = 1'b0;
    pipe_gap(gap);
    pipe_gap(gap);
    compare("pipe_gap_floor", gap, 4);

    run_crash(16, 16);

    expect_v("over_hold", SelState, 3);
    step_chk();
    press = 1'b1;
    expect_v("over_to_idle", SelState, 0);
    expect_v("idle_grst", SelGrst, 1);
    expect_v("idle_score_hold", SelScore, 16);
    step_chk();
    press = 1'b0;
    expect_v("idle_stay", SelState, 0);
    step_chk();
    press = 1'b1;
    expect_v("replay_state", SelState, 1);
    expect_v("replay_score", SelScore, 0);
    expect_v("replay_level", SelLevel, 0);
    expect_v("replay_high", SelHigh, 16);
    expect_v("replay_grst", SelGrst, 0);
    step_chk();
    press = 1'b0;
    score_pulse = 1'b1;
    expect_v("replay_pt", SelScore, 1);
    step_chk();
    run_crash(1, 16);

    press = 1'b1;
    step_chk();
    press = 1'b0;
    step_chk();
    press = 1'b1;
    expect_v("game3_state", SelState, 1);
    step_chk();
    press = 1'b0;
    step_chk();
    rst = 1'b0;
    expect_v("midrst_state", SelState, 0);
    expect_v("midrst_high", SelHigh, 0);
    expect_v("midrst_grst", SelGrst, 1);
    expect_v("midrst_score", SelScore, 0);
    step_chk();
    rst = 1'b1;

    step_chk();
    press = 1'b1;
    expect_v("game4_state", SelState, 1);
    step_chk();
    press = 1'b0;
    for (int i = 1; i <= 1000; i++) begin
      score_pulse = 1'b1;
      if (i >= 998) expect_v($sformatf("score_sat_%0d", i), SelScore, (i > 999) ? 999 : i);
      step_chk();
    end
    score_pulse = 1'b0;
    expect_v("score_final", SelScore, 999);
    expect_v("level_final", SelLevel, 7);
    step_chk();
    run_crash(999, 999);

    if (exp_q.size() != 0) compare("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
